// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 port arbiter: FSM states, owner and op codes.
// STARVE_MAX bounds consecutive D grants when L2_ARB_D_PRIORITY_EN is set.
package l2_arb_pkg;

  localparam int STARVE_MAX = 4;
  localparam int RUN_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/l2_arb_pick.sv
// Owner select for the L2 port: round-robin, or D-first with I anti-starve
// when L2_ARB_D_PRIORITY_EN is defined (d_run port only exists then).
// Ports: i_req, d_req, last_owner, [d_run] in; valid, owner out.
module l2_arb_pick
  import l2_arb_pkg::*;
(
  input  logic             i_req,
  input  logic             d_req,
  input  owner_t           last_owner,
`ifdef L2_ARB_D_PRIORITY_EN
  input  logic [RUN_W-1:0] d_run,
`endif
  output logic             valid,
  output owner_t           owner
);

`ifdef L2_ARB_D_PRIORITY_EN
  logic starve;
  assign starve = i_req && (d_run == RUN_W'(STARVE_MAX));

  always_comb begin
    valid = i_req | d_req;
    owner = OWN_I;
    unique case (1'b1)
      starve:          owner = OWN_I;
      d_req & ~starve: owner = OWN_D;
      default:         owner = OWN_I;
    endcase
  end
`else
  // last_owner only matters when both sides are waiting
  always_comb begin
    valid = i_req | d_req;
    owner = OWN_I;
    unique case (1'b1)
      i_req & d_req:
        owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
      d_req & ~i_req:  owner = OWN_D;
      default:         owner = OWN_I;
    endcase
  end
`endif

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between I-cache reads and D-cache reads/word writes.
// Ports: clk, proc_reset; I_* and D_* request/response; L2_* to the L2.
// Option: L2_ARB_D_PRIORITY_EN selects D-first with I anti-starvation.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int LINE_W = 128,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              I_read,
  input  logic [ADDR_W-1:0] I_addr,
  output logic [LINE_W-1:0] I_rdata,
  output logic              I_ready,
  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic [LINE_W-1:0] D_rdata,
  output logic              D_ready,
  output logic              L2_read,
  output logic              L2_write,
  output logic [ADDR_W-1:0] L2_addr,
  output logic [DATA_W-1:0] L2_wdata,
  input  logic [LINE_W-1:0] L2_rdata,
  input  logic              L2_ready
);

  state_t            state;
  owner_t            last_owner;
  owner_t            pick;
  logic              pick_v;
  op_t               d_op;
  logic [LINE_W-1:0] i_line;
  logic [LINE_W-1:0] d_line;

  // a write wins when the D side raises both strobes
  assign d_op = D_write ? OP_WR : OP_RD;

  // each side keeps its own line so the idle side's rdata holds
  assign I_rdata = i_line;
  assign D_rdata = d_line;

`ifdef L2_ARB_D_PRIORITY_EN
  logic [RUN_W-1:0] d_run;
`endif

  l2_arb_pick u_pick (
    .i_req      (I_read),
    .d_req      (D_read | D_write),
    .last_owner (last_owner),
`ifdef L2_ARB_D_PRIORITY_EN
    .d_run      (d_run),
`endif
    .valid      (pick_v),
    .owner      (pick)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_owner <= OWN_I;
      L2_read    <= 1'b0;
      L2_write   <= 1'b0;
      L2_addr    <= '0;
      L2_wdata   <= '0;
      I_ready    <= 1'b0;
      D_ready    <= 1'b0;
      i_line     <= '0;
      d_line     <= '0;
`ifdef L2_ARB_D_PRIORITY_EN
      d_run      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_v) begin
            last_owner <= pick;
            state      <= BUSY;
            if (pick == OWN_D) begin
              L2_addr  <= D_addr;
              L2_read  <= (d_op == OP_RD);
              L2_write <= (d_op == OP_WR);
              if (d_op == OP_WR) L2_wdata <= D_wdata;
            end else begin
              L2_addr  <= I_addr;
              L2_read  <= 1'b1;
              L2_write <= 1'b0;
            end
`ifdef L2_ARB_D_PRIORITY_EN
            if (pick == OWN_I)
              d_run <= '0;
            else if (d_run != RUN_W'(STARVE_MAX))
              d_run <= d_run + 1'b1;
`endif
          end
        end
        BUSY: begin
          if (L2_ready) begin
            L2_read  <= 1'b0;
            L2_write <= 1'b0;
            state    <= RESP;
            if (last_owner == OWN_D) begin
              d_line  <= L2_rdata;
              D_ready <= 1'b1;
            end else begin
              i_line  <= L2_rdata;
              I_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          I_ready <= 1'b0;
          D_ready <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: vector table plus hand-written sequences,
// scoreboard queue of expected grants, 3-cycle L2 model.
module tb_l2_port_arbiter;
  import l2_arb_pkg::*;

  logic          clk = 1'b0;
  logic          proc_reset = 1'b1;
  logic          I_read = 1'b0;
  logic [29:0]   I_addr = '0;
  logic [127:0]  I_rdata;
  logic          I_ready;
  logic          D_read = 1'b0;
  logic          D_write = 1'b0;
  logic [29:0]   D_addr = '0;
  logic [31:0]   D_wdata = '0;
  logic [127:0]  D_rdata;
  logic          D_ready;
  logic          L2_read;
  logic          L2_write;
  logic [29:0]   L2_addr;
  logic [31:0]   L2_wdata;
  logic [127:0]  L2_rdata = '0;
  logic          L2_ready = 1'b0;

  always #5 clk = ~clk;

  l2_port_arbiter dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .I_read     (I_read),
    .I_addr     (I_addr),
    .I_rdata    (I_rdata),
    .I_ready    (I_ready),
    .D_read     (D_read),
    .D_write    (D_write),
    .D_addr     (D_addr),
    .D_wdata    (D_wdata),
    .D_rdata    (D_rdata),
    .D_ready    (D_ready),
    .L2_read    (L2_read),
    .L2_write   (L2_write),
    .L2_addr    (L2_addr),
    .L2_wdata   (L2_wdata),
    .L2_rdata   (L2_rdata),
    .L2_ready   (L2_ready)
  );

  typedef struct {
    logic        own;
    logic [29:0] addr;
    logic        wr;
    logic [31:0] wd;
  } exp_t;

  typedef struct {
    logic        i;
    logic        dr;
    logic        dw;
    logic [29:0] ia;
    logic [29:0] da;
    logic [31:0] wd;
  } vec_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  bit   glitch = 1'b0;
  int   d_repeat = 0;
  logic m_last = 1'b0;
  int   m_drun = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  function automatic logic [127:0] line_of(input logic [29:0] a);
    return {4{32'(a)}};
  endfunction

  // reference grant order model
  task automatic grant(input logic own, input logic [29:0] a,
                       input logic wr, input logic [31:0] wd);
    exp_t e;
    e.own = own; e.addr = a; e.wr = wr; e.wd = wd;
    q.push_back(e);
    m_last = own;
    if (own) m_drun = (m_drun < STARVE_MAX) ? m_drun + 1 : m_drun;
    else m_drun = 0;
  endtask

  function automatic logic first_d();
`ifdef L2_ARB_D_PRIORITY_EN
    return !(m_drun == STARVE_MAX);
`else
    return (m_last == 1'b0);
`endif
  endfunction

  // L2 model: ready on the third strobe cycle, rdata = {4{addr}}
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (glitch) begin
        L2_ready = 1'b1; L2_rdata = '1; glitch = 1'b0; cnt = 0;
      end else if (L2_ready) begin
        L2_ready = 1'b0; cnt = 0;
      end else if (L2_read | L2_write) begin
        cnt++;
        if (cnt == 3) begin
          L2_ready = 1'b1;
          L2_rdata = line_of(L2_addr);
        end
      end else cnt = 0;
    end
  end

  // monitor: strobe contents and ready pulses against queue front
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (mon_en) begin
        if (L2_read | L2_write) begin
          if (q.size() == 0) fail("l2_strobe_unexpected");
          else begin
            chk("l2_read", L2_read, !q[0].wr);
            chk("l2_write", L2_write, q[0].wr);
            chk("l2_addr", L2_addr, q[0].addr);
            if (q[0].wr) chk("l2_wdata", L2_wdata, q[0].wd);
          end
        end
        if (I_ready | D_ready) begin
          chk("ready_both", I_ready & D_ready, 0);
          if (q.size() == 0) fail("ready_spurious");
          else begin
            e = q.pop_front();
            chk("ready_owner", D_ready, e.own);
            if (!e.wr) begin
              if (e.own) chk("D_rdata", D_rdata, line_of(e.addr));
              else chk("I_rdata", I_rdata, line_of(e.addr));
            end
            if (D_ready) begin
              if (d_repeat > 0) d_repeat--;
              else begin D_read = 1'b0; D_write = 1'b0; end
            end
            if (I_ready) I_read = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail("drain_timeout");
      q.delete();
      I_read = 1'b0; D_read = 1'b0; D_write = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    proc_reset = 1'b1;
    I_read = 1'b0; D_read = 1'b0; D_write = 1'b0;
    q.delete();
    m_last = 1'b0; m_drun = 0; d_repeat = 0;
    repeat (2) @(posedge clk);
    #1;
    proc_reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic dq;
    dq = v.dr | v.dw;
    I_read = v.i; I_addr = v.ia;
    D_read = v.dr; D_write = v.dw; D_addr = v.da; D_wdata = v.wd;
    if (v.i && dq) begin
      if (first_d()) begin
        grant(1'b1, v.da, v.dw, v.wd);
        grant(1'b0, v.ia, 1'b0, 0);
      end else begin
        grant(1'b0, v.ia, 1'b0, 0);
        grant(1'b1, v.da, v.dw, v.wd);
      end
    end else if (dq) grant(1'b1, v.da, v.dw, v.wd);
    else if (v.i) grant(1'b0, v.ia, 1'b0, 0);
    wait_drain();
  endtask

  vec_t vt[7];

  initial begin
    int n;
    vt[0] = '{1, 0, 0, 30'h100, 30'h0, 32'h0};
    vt[1] = '{1, 1, 0, 30'h140, 30'h80, 32'h0};
    vt[2] = '{0, 0, 1, 30'h0, 30'h20, 32'hDEADBEEF};
    vt[3] = '{0, 1, 1, 30'h0, 30'h24, 32'h12345678};
    vt[4] = '{1, 0, 1, 30'h200, 30'h44, 32'hCAFEF00D};
    vt[5] = '{0, 1, 0, 30'h0, 30'h3FFFFFFF, 32'h0};
    vt[6] = '{1, 1, 0, 30'h0, 30'h10, 32'h0};

    repeat (2) @(posedge clk);
    #3;
    chk("rst_L2_read", L2_read, 0);
    chk("rst_L2_write", L2_write, 0);
    chk("rst_L2_addr", L2_addr, 0);
    chk("rst_L2_wdata", L2_wdata, 0);
    chk("rst_I_ready", I_ready, 0);
    chk("rst_D_ready", D_ready, 0);
    chk("rst_I_rdata", I_rdata, 0);
    chk("rst_D_rdata", D_rdata, 0);
    do_reset();

    // lone I read: strobe one cycle after, ready three cycles later
    I_addr = 30'h100; I_read = 1'b1;
    grant(1'b0, 30'h100, 1'b0, 0);
    @(posedge clk); #3;
    chk("lat_L2_read", L2_read, 1);
    n = 1;
    while (!I_ready && n < 20) begin
      @(posedge clk); #3;
      n++;
    end
    chk("lat_ready_cycles", n, 4);
    chk("lat_I_rdata", I_rdata, {4{32'h100}});
    chk("lat_D_ready", D_ready, 0);
    wait_drain();

    for (int k = 0; k < 7; k++) run_vec(vt[k]);

    // reset in BUSY aborts without a ready pulse
    I_addr = 30'h300; I_read = 1'b1;
    grant(1'b0, 30'h300, 1'b0, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("busy_L2_read", L2_read, 1);
    mon_en = 1'b0;
    proc_reset = 1'b1; I_read = 1'b0;
    q.delete(); m_last = 1'b0; m_drun = 0;
    @(posedge clk); #3;
    chk("abort_L2_read", L2_read, 0);
    chk("abort_L2_write", L2_write, 0);
    proc_reset = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #3;
      chk("abort_no_ready", {I_ready, D_ready}, 0);
    end
    @(posedge clk); #1;
    run_vec('{1, 0, 0, 30'h304, 30'h0, 32'h0});

    // L2_ready while idle is ignored
    glitch = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #3;
      chk("glitch_quiet", {I_ready, D_ready, L2_read, L2_write}, 0);
    end

    // D held back-to-back against a held I read
    do_reset();
    begin
      int ir = 1;
      int dr = 4;
      logic own;
      D_addr = 30'h50; D_read = 1'b1;
      I_addr = 30'h60; I_read = 1'b1;
      d_repeat = 3;
      while (ir != 0 || dr > 0) begin
        if (ir != 0 && dr > 0) own = first_d();
        else own = (dr > 0);
        if (own) begin grant(1'b1, 30'h50, 1'b0, 0); dr--; end
        else begin grant(1'b0, 30'h60, 1'b0, 0); ir = 0; end
      end
`ifdef L2_ARB_D_PRIORITY_EN
      chk("starve_order_last_is_I", q[4].own, 0);
`else
      chk("rr_order_second_is_I", q[1].own, 0);
`endif
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
